dram_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the byte-banked data RAM (ports ce/we/addr/mem_sel/mem_data_i/mem_data_o).
- Shares the RAM between the MEM-stage load/store unit (master 0) and a debug/DMA port (master 1).
- Registers each accepted request, drives exactly one RAM access cycle, captures read data and returns a one-cycle response.
- Keeps saturating per-master grant counters for profiling.

---
 rtl/dram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_dram_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: two-master arbiter/sequencer in front of a byte-banked data RAM.
// Master 0 is the MEM-stage load/store unit and master 1 is the debug/DMA port.
// An accepted request is latched, given exactly one RAM access cycle (ACCESS),
// then answered with a one-cycle rvalid (RESP). Arbitration runs in IDLE and RESP,
// so the peak rate is one access every two cycles.
// Optional build macro DRAM_ARB_FIXED_PRIO_EN: when defined, m0 always wins a tie.
// Otherwise ties are resolved round-robin.
// Handshake: a master holds req and payload stable until it sees gnt=1. gnt is high
// for exactly the single ACCESS cycle of its own request. rvalid and rdata follow
// one cycle later. The master may drop or re-raise req from the gnt cycle onward.
module dram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [CNT_W-1:0]    gnt_cnt0,
  output logic [CNT_W-1:0]    gnt_cnt1
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                owner;
  logic                last_winner;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [SEL_W-1:0]    lat_sel;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic                any_req;
  logic                winner;
  logic                arb_slot;
  logic                accept;

  assign any_req  = m0_req | m1_req;
  assign arb_slot = (state == IDLE) || (state == RESP);
  assign accept   = arb_slot && any_req;

  // Pick the winner among current requesters. With a single requester it wins outright.
  always_comb begin
    winner = 1'b0;
    if (m0_req && !m1_req) begin
      winner = 1'b0;
    end else if (!m0_req && m1_req) begin
      winner = 1'b1;
    end else if (m0_req && m1_req) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_winner;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: ACCESS always lasts one cycle, and IDLE/RESP both arbitrate.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any_req ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = any_req ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: RAM strobes and handshake pulses decode from state and owner.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    case (state)
      ACCESS: begin
        ram_ce = 1'b1;
        ram_we = lat_we;
        m0_gnt = (owner == 1'b0);
        m1_gnt = (owner == 1'b1);
      end
      RESP: begin
        m0_rvalid = (owner == 1'b0);
        m1_rvalid = (owner == 1'b1);
      end
      default: ;
    endcase
  end

  assign ram_addr  = lat_addr;
  assign ram_sel   = lat_sel;
  assign ram_wdata = lat_wdata;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

  // Latch the winning request. Between accesses the RAM bus keeps the last payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= 1'b0;
      last_winner <= 1'b1;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_sel     <= '0;
      lat_wdata   <= '0;
    end else if (accept) begin
      owner       <= winner;
      last_winner <= winner;
      lat_we      <= winner ? m1_we    : m0_we;
      lat_addr    <= winner ? m1_addr  : m0_addr;
      lat_sel     <= winner ? m1_sel   : m0_sel;
      lat_wdata   <= winner ? m1_wdata : m0_wdata;
    end
  end

  // Capture read data at the end of ACCESS into the owner's register only.
  // A write returns zero, and the other master's data is left untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state == ACCESS) begin
      if (owner == 1'b0) begin
        rdata0_q <= lat_we ? '0 : ram_rdata;
      end else begin
        rdata1_q <= lat_we ? '0 : ram_rdata;
      end
    end
  end

  // Saturating grant counters used for profiling. They bump when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (accept) begin
      if (winner == 1'b0) begin
        if (gnt_cnt0 != {CNT_W{1'b1}}) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      end else begin
        if (gnt_cnt1 != {CNT_W{1'b1}}) gnt_cnt1 <= gnt_cnt1 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed testbench for dram_arbiter (CNT_W=4 so counter saturation is reachable).
// Inputs change 1 time unit after the rising edge, and outputs are sampled on the falling edge.
module tb_dram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
  logic [3:0]  gnt_cnt0, gnt_cnt1;

  int vectors;
  int fails;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dram_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // RAM model: combinational read, byte-enabled synchronous write, bench-controlled preload
  logic [31:0] mem [0:255];
  logic        preload;
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'hDEADBEEF;
      mem[8'h81] <= 32'hCAFEF00D;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  // one-hot handshake check on every cycle
  always @(negedge clk) begin
    if (rst_n && !preload) begin
      vectors++;
      assert (!(m0_gnt && m1_gnt) && !(m0_rvalid && m1_rvalid)) else begin
        fails++;
        $error("FAIL onehot: gnt=%b%b rvalid=%b%b required not both", m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_addr = addr; m0_sel = 4'hF; m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_addr = addr; m1_sel = 4'hF; m1_wdata = wdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  logic exp_own;
  logic exp_last;

  initial begin
    vectors = 0;
    fails = 0;
    preload = 1'b1;
    drive_m0(0, 0, 0, 0);
    drive_m1(0, 0, 0, 0);
    rst_n = 1'b0;
    tick(); tick();
    preload = 1'b0;
    sample();
    chk("rst_ce", {31'b0, ram_ce}, 0);
    chk("rst_gnt", {30'b0, m0_gnt, m1_gnt}, 0);
    chk("rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_cnt", {24'b0, gnt_cnt0, gnt_cnt1}, 0);
    chk("rst_rdata0", m0_rdata, 0);
    rst_n = 1'b1;
    tick();

    // single read by m0
    drive_m0(1, 0, 32'h100, 0);
    tick(); sample();
    chk("rd_gnt0", {31'b0, m0_gnt}, 1);
    chk("rd_gnt1", {31'b0, m1_gnt}, 0);
    chk("rd_ce", {30'b0, ram_ce, ram_we}, 32'h2);
    chk("rd_addr", ram_addr, 32'h100);
    tick();
    drive_m0(0, 0, 32'h100, 0);
    sample();
    chk("rd_rvalid0", {31'b0, m0_rvalid}, 1);
    chk("rd_rdata0", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_quiet", {30'b0, m1_rvalid, m1_gnt}, 0);
    chk("rd_m1_rdata", m1_rdata, 0);
    chk("rd_resp_ce", {31'b0, ram_ce}, 0);
    tick(); sample();
    chk("rd_idle_rv", {31'b0, m0_rvalid}, 0);
    chk("rd_hold_addr", ram_addr, 32'h100);
    chk("rd_cnt0", {28'b0, gnt_cnt0}, 1);

    // write then read by m1
    drive_m1(1, 1, 32'h200, 32'h12345678);
    tick(); sample();
    chk("wr_gnt1", {31'b0, m1_gnt}, 1);
    chk("wr_we", {30'b0, ram_ce, ram_we}, 32'h3);
    chk("wr_wdata", ram_wdata, 32'h12345678);
    tick();
    drive_m1(0, 0, 32'h200, 0);
    sample();
    chk("wr_rvalid1", {31'b0, m1_rvalid}, 1);
    chk("wr_rdata1", m1_rdata, 0);
    chk("wr_m0_hold", m0_rdata, 32'hDEADBEEF);
    chk("wr_mem", mem[8'h80], 32'h12345678);
    tick();
    drive_m1(1, 0, 32'h200, 0);
    tick(); tick();
    drive_m1(0, 0, 32'h200, 0);
    sample();
    chk("rb_rvalid1", {31'b0, m1_rvalid}, 1);
    chk("rb_rdata1", m1_rdata, 32'h12345678);
    tick(); sample();
    chk("rb_cnt", {24'b0, gnt_cnt0, gnt_cnt1}, 32'h12);

    // back-to-back: m0 re-raises with a new address in its gnt cycle
    drive_m0(1, 0, 32'h100, 0);
    tick();
    drive_m0(1, 0, 32'h204, 0);
    sample();
    chk("b2b_gnt_a", {31'b0, m0_gnt}, 1);
    chk("b2b_addr_a", ram_addr, 32'h100);
    tick(); sample();
    chk("b2b_rv_a", {31'b0, m0_rvalid}, 1);
    chk("b2b_rd_a", m0_rdata, 32'hDEADBEEF);
    tick();
    drive_m0(0, 0, 32'h204, 0);
    sample();
    chk("b2b_gnt_b", {31'b0, m0_gnt}, 1);
    chk("b2b_addr_b", ram_addr, 32'h204);
    tick(); sample();
    chk("b2b_rd_b", m0_rdata, 32'hCAFEF00D);
    tick(); sample();
    chk("b2b_cnt0", {28'b0, gnt_cnt0}, 3);

    // reset in the middle of an access
    drive_m1(1, 1, 32'h300, 32'h55);
    tick(); sample();
    chk("ra_gnt1", {31'b0, m1_gnt}, 1);
    #1;
    rst_n = 1'b0;
    drive_m1(0, 0, 0, 0);
    sample();
    chk("ra_gnt", {30'b0, m0_gnt, m1_gnt}, 0);
    chk("ra_ce", {31'b0, ram_ce}, 0);
    chk("ra_cnt", {24'b0, gnt_cnt0, gnt_cnt1}, 0);
    chk("ra_state", {30'b0, dut.state}, 0);
    tick();
    rst_n = 1'b1;
    sample();
    chk("ra_no_rv", {30'b0, m0_rvalid, m1_rvalid}, 0);

    // contention from reset: both hold req continuously
    drive_m0(1, 0, 32'h100, 0);
    drive_m1(1, 0, 32'h200, 0);
    exp_last = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
      exp_own = 1'b0;
`else
      exp_own = ~exp_last;
`endif
      exp_last = exp_own;
      tick(); sample();
      chk("ct_gnt", {30'b0, m0_gnt, m1_gnt}, exp_own ? 32'h1 : 32'h2);
      tick();
      if (g == 3) begin
        drive_m0(0, 0, 0, 0);
        drive_m1(0, 0, 0, 0);
      end
      sample();
      chk("ct_rv", {30'b0, m0_rvalid, m1_rvalid}, exp_own ? 32'h1 : 32'h2);
      if (exp_own) chk("ct_rd1", m1_rdata, 32'h12345678);
      else chk("ct_rd0", m0_rdata, 32'hDEADBEEF);
    end
    tick(); sample();
`ifdef DRAM_ARB_FIXED_PRIO_EN
    chk("ct_cnt", {24'b0, gnt_cnt0, gnt_cnt1}, 32'h40);
`else
    chk("ct_cnt", {24'b0, gnt_cnt0, gnt_cnt1}, 32'h22);
`endif

    // saturation: 20 grants to m0 from a fresh reset
    do_reset();
    drive_m0(1, 0, 32'h100, 0);
    for (int c = 0; c < 30; c++) tick();
    sample();
    chk("sat_mid", {28'b0, gnt_cnt0}, 15);
    for (int c = 0; c < 10; c++) tick();
    drive_m0(0, 0, 0, 0);
    tick(); tick(); sample();
    chk("sat_cnt0", {28'b0, gnt_cnt0}, 15);
    chk("sat_cnt1", {28'b0, gnt_cnt1}, 0);
    chk("sat_idle", {31'b0, ram_ce}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
